// File: rtl/pp_hazard_ctrl_if.sv
// pp_hazard_ctrl_if: signal bundle between the CPU pipeline and the hazard controller.
//   Pipeline -> controller: ID/EX/MEM/WR register fields and control bits, EX_MDStart, Redirect.
//   Controller -> pipeline: PC/IFID/IDEX enables, the three flushes, FwdA/FwdB, MD_Busy,
//   MD_Done, StallCnt, FlushCnt.
//   modport master = pipeline side, modport slave = hazard controller side.
interface pp_hazard_ctrl_if #(
    parameter int RW    = 5,
    parameter int CNT_W = 16
);
    logic [RW-1:0]    ID_Rs, ID_Rt;
    logic             ID_UseRs, ID_UseRt;
    logic [RW-1:0]    EX_Rs, EX_Rt, EX_Rw;
    logic             EX_RegWr, EX_MemtoReg, EX_MDStart;
    logic [RW-1:0]    MEM_Rw;
    logic             MEM_RegWr;
    logic [RW-1:0]    WR_Rw;
    logic             WR_RegWr;
    logic             Redirect;

    logic             PC_EN, IFID_EN, IDEX_EN;
    logic             IFID_Flush, IDEX_Flush, EXMEM_Flush;
    logic [1:0]       FwdA, FwdB;
    logic             MD_Busy, MD_Done;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    modport master (
        output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
        output EX_Rs, EX_Rt, EX_Rw, EX_RegWr, EX_MemtoReg, EX_MDStart,
        output MEM_Rw, MEM_RegWr, WR_Rw, WR_RegWr, Redirect,
        input  PC_EN, IFID_EN, IDEX_EN, IFID_Flush, IDEX_Flush, EXMEM_Flush,
        input  FwdA, FwdB, MD_Busy, MD_Done, StallCnt, FlushCnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
        input  EX_Rs, EX_Rt, EX_Rw, EX_RegWr, EX_MemtoReg, EX_MDStart,
        input  MEM_Rw, MEM_RegWr, WR_Rw, WR_RegWr, Redirect,
        output PC_EN, IFID_EN, IDEX_EN, IFID_Flush, IDEX_Flush, EXMEM_Flush,
        output FwdA, FwdB, MD_Busy, MD_Done, StallCnt, FlushCnt
    );
endinterface

// File: rtl/pp_hazard_ctrl.sv
// pp_hazard_ctrl: hazard controller for the 5-stage pipeline.
//   EX-operand forwarding select, load-use stall, multi-cycle EX stall (IDLE/BUSY FSM with
//   down-counter), control-hazard flush (depth set by BR_STAGE), and saturating stall/flush
//   performance counters.
//   Ports: Clk  - rising-edge clock
//          Clr  - synchronous active-high reset
//          hz   - pp_hazard_ctrl_if.slave bundle (pipeline fields in, enables/flushes/selects out)
module pp_hazard_ctrl #(
    parameter int RW       = 5,
    parameter int MD_LAT   = 4,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16
) (
    input logic              Clk,
    input logic              Clr,
    pp_hazard_ctrl_if.slave  hz
);
    localparam int CW = $clog2(MD_LAT + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WR  = 2'b10;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             busy, mds, lu, pc_en;

    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic          mem_wr,
        input logic [RW-1:0] mem_rw,
        input logic          wr_wr,
        input logic [RW-1:0] wr_rw
    );
        if (mem_wr && mem_rw != '0 && mem_rw == src)
            return FWD_MEM;
        else if (wr_wr && wr_rw != '0 && wr_rw == src)
            return FWD_WR;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        busy = (state == BUSY);
        mds  = (!busy && hz.EX_MDStart) || (busy && cnt != '0);
        lu   = hz.EX_MemtoReg && hz.EX_RegWr && hz.EX_Rw != '0 &&
               ((hz.ID_UseRs && hz.ID_Rs == hz.EX_Rw) ||
                (hz.ID_UseRt && hz.ID_Rt == hz.EX_Rw));
    end

    always_comb begin
        if (Clr) begin
            hz.FwdA = FWD_RF;
            hz.FwdB = FWD_RF;
        end else begin
            hz.FwdA = fwd_sel(hz.EX_Rs, hz.MEM_RegWr, hz.MEM_Rw, hz.WR_RegWr, hz.WR_Rw);
            hz.FwdB = fwd_sel(hz.EX_Rt, hz.MEM_RegWr, hz.MEM_Rw, hz.WR_RegWr, hz.WR_Rw);
        end
    end

    // Priority: Clr > Redirect > multi-cycle stall > load-use.
    always_comb begin
        pc_en          = 1'b1;
        hz.IFID_EN     = 1'b1;
        hz.IDEX_EN     = 1'b1;
        hz.IFID_Flush  = 1'b0;
        hz.IDEX_Flush  = 1'b0;
        hz.EXMEM_Flush = 1'b0;
        if (Clr) begin
            hz.IFID_Flush  = 1'b1;
            hz.IDEX_Flush  = 1'b1;
            hz.EXMEM_Flush = 1'b1;
        end else if (hz.Redirect) begin
            hz.IFID_Flush  = 1'b1;
            hz.IDEX_Flush  = 1'b1;
            hz.EXMEM_Flush = (BR_STAGE == 2);
        end else if (mds) begin
            // ID/EX is held, not bubbled, so a coincident load-use needs no bubble here.
            pc_en          = 1'b0;
            hz.IFID_EN     = 1'b0;
            hz.IDEX_EN     = 1'b0;
            hz.EXMEM_Flush = 1'b1;
        end else if (lu) begin
            pc_en          = 1'b0;
            hz.IFID_EN     = 1'b0;
            hz.IDEX_Flush  = 1'b1;
        end
    end

    assign hz.PC_EN    = pc_en;
    assign hz.MD_Busy  = busy;
    assign hz.MD_Done  = busy && cnt == '0 && !Clr;
    assign hz.StallCnt = stall_cnt;
    assign hz.FlushCnt = flush_cnt;

    always_ff @(posedge Clk) begin
        if (Clr || hz.Redirect) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.EX_MDStart) begin
                        state <= BUSY;
                        cnt   <= CW'(MD_LAT - 1);
                    end
                end
                default: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.Redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/pp_hazard_ctrl.md
# pp_hazard_ctrl

Parametrised hazard controller for the 5-stage pipelined CPU (IF -> ID -> EX -> MEM -> WR). It replaces the single load-use detector with one unit that does four jobs: EX-operand forwarding select, load-use stall, multi-cycle EX operation stall (FSM plus counter), and control-hazard flush. Flush depth is chosen by the branch-resolution stage. The block also keeps saturating stall and flush performance counters, and drives every pipeline-register enable and flush in the CPU top.

## Interface
Parameters:
- RW, 5: register-address width.
- MD_LAT, 4: multi-cycle EX operation latency in cycles; minimum 1.
- BR_STAGE, 2: branch/jump resolution stage. 1 = EX, 2 = MEM.
- CNT_W, 16: width of each performance counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clr  in  1  synchronous, active-high reset.
- ID_Rs, ID_Rt  in  RW  source fields of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1  the instruction in ID actually reads the corresponding source.
- EX_Rs, EX_Rt  in  RW  source registers of the instruction in EX.
- EX_Rw  in  RW  destination of the instruction in EX (after RegDst).
- EX_RegWr, EX_MemtoReg  in  1  write-back control bits of the instruction in EX.
- EX_MDStart  in  1  instruction in EX is a multi-cycle operation; held high for its whole EX residency.
- MEM_Rw  in  RW; MEM_RegWr  in  1  destination and write enable in MEM.
- WR_Rw  in  RW; WR_RegWr  in  1  destination and write enable in WR.
- Redirect  in  1  PCSrc from the resolution stage.
- PC_EN, IFID_EN, IDEX_EN  out  1  enables for the PC and the pipeline registers.
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1  load a bubble into that register on the next edge.
- FwdA, FwdB  out  2  EX operand select: 00 register file, 01 MEM ALUout, 10 WR RegDin.
- MD_Busy  out  1  FSM is in BUSY.
- MD_Done  out  1  final cycle of a multi-cycle operation.
- StallCnt, FlushCnt  out  CNT_W  performance counters.

## Operation
Forwarding (combinational):
- FwdA = 01 when MEM_RegWr && MEM_Rw != 0 && MEM_Rw == EX_Rs.
- Otherwise FwdA = 10 when WR_RegWr && WR_Rw != 0 && WR_Rw == EX_Rs.
- Otherwise FwdA = 00.
- FwdB uses the same rules against EX_Rt.
- MEM has priority over WR. Register 0 is never forwarded.

Load-use condition LU: EX_MemtoReg && EX_RegWr && EX_Rw != 0 && ((ID_UseRs && ID_Rs == EX_Rw) || (ID_UseRt && ID_Rt == EX_Rw)).

Multi-cycle FSM, states IDLE and BUSY, counter cnt of width clog2(MD_LAT+1):
- IDLE with EX_MDStart && !Redirect: go to BUSY, load cnt <= MD_LAT-1.
- BUSY: cnt decrements each cycle.
- BUSY with cnt == 0: return to IDLE and pulse MD_Done.
- EX_MDStart is ignored outside IDLE.
- MDS (MD stall) = (IDLE && EX_MDStart) || (BUSY && cnt != 0).
- The multi-cycle unit latches its operands in the IDLE start cycle; FwdA/FwdB are valid in that cycle.

Control priority, highest first:
- Clr: PC_EN = IFID_EN = IDEX_EN = 1; all three flushes = 1.
- Redirect: PC_EN = 1, IFID_EN = 1, IDEX_EN = 1; IFID_Flush = 1, IDEX_Flush = 1; EXMEM_Flush = 1 only when BR_STAGE == 2. FSM forced to IDLE on the next edge.
- MDS: PC_EN = 0, IFID_EN = 0, IDEX_EN = 0, EXMEM_Flush = 1. ID/EX is held rather than bubbled, so a coincident LU inserts no bubble.
- LU: PC_EN = 0, IFID_EN = 0, IDEX_Flush = 1.
- None of the above: enables = 1, flushes = 0.

Counters:
- StallCnt increments in every cycle with PC_EN == 0 and Clr == 0.
- FlushCnt increments in every cycle with Redirect == 1 and Clr == 0.
- Both saturate at all-ones and do not wrap.

## Timing
- All enables, flushes, FwdA/FwdB and MD_Done are combinational from the inputs and current state, with zero latency.
- FSM state and counters update on the rising edge of Clk.
- Reset values: state IDLE, cnt 0, StallCnt 0, FlushCnt 0, MD_Busy 0, MD_Done 0. While Clr is high, FwdA = FwdB = 00.
- Clr asserted mid-BUSY: next state IDLE, no MD_Done.
- LU stall lasts exactly 1 cycle. Afterwards the load is in WR and the dependent instruction takes FwdX = 10.
- A multi-cycle instruction entering EX at cycle t:
  - stalls are asserted in cycles t .. t+MD_LAT-1;
  - MD_Busy is high in t+1 .. t+MD_LAT;
  - MD_Done is high in t+MD_LAT;
  - the instruction leaves EX on the edge that ends t+MD_LAT.
- MD_LAT == 1: the cycle-t stall lasts one cycle, and MD_Done fires in t+1.
- Redirect in the same cycle as an IDLE start: no BUSY entry.

## Test plan
- Forwarding: EX_Rs = 3, MEM_Rw = 3, WR_Rw = 3, both RegWr = 1 -> FwdA = 01. Then MEM_RegWr = 0 -> FwdA = 10. Then EX_Rs = MEM_Rw = WR_Rw = 0 -> FwdA = 00.
- Load-use: EX_MemtoReg = 1, EX_RegWr = 1, EX_Rw = 5, ID_Rs = 5, ID_UseRs = 1 for one cycle -> PC_EN = 0, IFID_EN = 0, IDEX_Flush = 1; StallCnt goes 0 -> 1. With ID_UseRs = 0 -> no stall.
- MD_LAT = 4, EX_MDStart held from cycle t -> stall in t..t+3, MD_Busy high in t+1..t+4, MD_Done only in t+4, EXMEM_Flush = 1 in t..t+3, StallCnt = 4.
- BR_STAGE = 2, Redirect at t+2 during BUSY, with LU also true -> PC_EN = 1, all three flushes = 1, IDLE at t+3, no MD_Done, FlushCnt = 1.
- CNT_W = 4, LU held 20 cycles -> StallCnt = 15 and holds there.
- Clr pulsed in BUSY at cnt = 2 -> next cycle IDLE, both counters 0, no stall, MD_Done = 0.
